// File: rtl/miner_pkg.sv
// Shared types and helpers for the share-collection path behind the SHA hasher.
package miner_pkg;

   localparam logic [7:0]  DEF_HDR_BYTE = 8'h4E;
   localparam int unsigned FRAME_LEN    = 9;

   typedef struct packed {
      logic [31:0] tstamp;
      logic [31:0] nonce;
   } hit_entry_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ser_state_t;

   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Small synchronous FIFO of hit entries with occupancy counter and registered flags.
module nonce_fifo
   import miner_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       i_push,
   input  hit_entry_t i_data,
   input  logic       i_pop,
   output hit_entry_t o_rd_data_c,
   output logic       o_full,
   output logic       o_empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   hit_entry_t    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          r_full;
   logic          r_empty;
   logic          w_do_push;
   logic          w_do_pop;

   // A push into a full FIFO is only taken when the same cycle frees a slot.
   assign w_do_pop  = i_pop & ~r_empty;
   assign w_do_push = i_push & (~r_full | w_do_pop);

   always_comb begin
      w_count_nxt = r_count;
      if (w_do_push && !w_do_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge CLK) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_rd_data_c = r_mem[r_rd_ptr];
   assign o_full      = r_full;
   assign o_empty     = r_empty;

endmodule

// File: rtl/nonce_collector.sv
// Screens hasher results against the share target, queues hits and frames them
// as header + nonce + time bytes toward the host link.
module nonce_collector
   import miner_pkg::*;
#(
   parameter int unsigned DEPTH        = 4,
   parameter logic [31:0] NONCE_OFFSET = 32'd8,
   parameter logic [7:0]  HDR_BYTE     = DEF_HDR_BYTE
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         valid_in,
   input  logic [255:0] result_in,
   input  logic [31:0]  time_in,
   input  logic [31:0]  nonce_in,
   input  logic [31:0]  target_in,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic [15:0]  hit_count,
   output logic [7:0]   drop_count,
   output logic         fifo_full
);

   localparam int unsigned      IDX_W    = 4;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

   logic             r_vld;
   logic             r_hit;
   logic [31:0]      r_time;
   logic [31:0]      r_nonce;
   logic             w_hit_d;
   logic             w_push;
   logic             w_drop;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   hit_entry_t       w_rd_data;
   logic [15:0]      r_hit_count;
   logic [7:0]       r_drop_count;
   ser_state_t       r_state;
   logic [IDX_W-1:0] r_idx;
   hit_entry_t       r_entry;
   logic [7:0]       r_tx_data;
   logic             r_tx_valid;
   logic             w_unused;

   // Only the two most-significant hash words take part in the share test.
   assign w_unused = ^result_in[255:64];
   assign w_hit_d  = valid_in & (result_in[31:0] == 32'd0) &
                     (bswap32(result_in[63:32]) <= target_in);

   function automatic logic [7:0] frame_byte(input hit_entry_t e, input logic [IDX_W-1:0] idx);
      logic [7:0] b;
      b = HDR_BYTE;
      case (idx)
         4'd1:    b = e.nonce[7:0];
         4'd2:    b = e.nonce[15:8];
         4'd3:    b = e.nonce[23:16];
         4'd4:    b = e.nonce[31:24];
         4'd5:    b = e.tstamp[7:0];
         4'd6:    b = e.tstamp[15:8];
         4'd7:    b = e.tstamp[23:16];
         4'd8:    b = e.tstamp[31:24];
         default: b = HDR_BYTE;
      endcase
      return b;
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_vld   <= 1'b0;
         r_hit   <= 1'b0;
         r_time  <= '0;
         r_nonce <= '0;
      end else begin
         r_vld   <= valid_in;
         r_hit   <= w_hit_d;
         r_time  <= time_in;
         r_nonce <= nonce_in - NONCE_OFFSET;
      end
   end

   // The serializer pops in IDLE, so a full FIFO can still absorb a hit that cycle.
   assign w_pop  = (r_state == ST_IDLE) & ~w_empty;
   assign w_push = r_vld & r_hit & (~w_full | w_pop);
   assign w_drop = r_vld & r_hit & w_full & ~w_pop;

   nonce_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK         (CLK),
      .RST         (RST),
      .i_push      (w_push),
      .i_data      ('{tstamp: r_time, nonce: r_nonce}),
      .i_pop       (w_pop),
      .o_rd_data_c (w_rd_data),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_hit_count  <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_push) r_hit_count <= r_hit_count + 16'd1;
         if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
      end
   end

   // Byte is only advanced on a handshake, so tx_data holds under backpressure.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_entry    <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_entry    <= w_rd_data;
                  r_idx      <= '0;
                  r_tx_data  <= HDR_BYTE;
                  r_tx_valid <= 1'b1;
                  r_state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (tx_ready) begin
                  if (r_idx == IDX_LAST) begin
                     r_tx_valid <= 1'b0;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_idx     <= r_idx + IDX_W'(1);
                     r_tx_data <= frame_byte(r_entry, r_idx + IDX_W'(1));
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tx_data    = r_tx_data;
   assign tx_valid   = r_tx_valid;
   assign hit_count  = r_hit_count;
   assign drop_count = r_drop_count;
   assign fifo_full  = w_full;

endmodule
